// File: rtl/atomic_counters_pkg.sv
// Shared defaults and read-request decode for the atomic 64-bit counter block.
package atomic_counters_pkg;

  localparam int unsigned     DATABUS_DEF  = 32;
  localparam int unsigned     COUNTLEN_DEF = 64;
  localparam longint unsigned FAST_INC_DEF = 64'd1_000_000;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LSB,
    RD_MSB
  } rd_kind_e;

  // atomic_i only matters while a request is present
  function automatic rd_kind_e rd_kind(input logic req, input logic atomic);
    if (!req) return RD_IDLE;
    return atomic ? RD_LSB : RD_MSB;
  endfunction

endpackage

// File: rtl/atomic_counters_counter64.sv
// Free-running wide counter: +1 or +FAST_INC per enabled edge, silent modulo wrap.
module counter64
  import atomic_counters_pkg::*;
#(
  parameter int unsigned     COUNTLEN = COUNTLEN_DEF,
  parameter longint unsigned FAST_INC = FAST_INC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trig_i,
  input  logic                fast_i,
  output logic [COUNTLEN-1:0] cnt_next_o
);

  localparam logic [COUNTLEN-1:0] INC_FAST = COUNTLEN'(FAST_INC);
  localparam logic [COUNTLEN-1:0] INC_ONE  = COUNTLEN'(1);

  logic [COUNTLEN-1:0] cnt_q, cnt_d, inc;

  always_comb begin
    inc = '0;
    if (trig_i) inc = fast_i ? INC_FAST : INC_ONE;
    cnt_d = cnt_q + inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Readers sample the post-increment value so a same-cycle read includes it
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/atomic_counters.sv
// Wide counter read over a narrow bus: atomic read returns LSB and snapshots MSB.
module atomic_counters
  import atomic_counters_pkg::*;
#(
  parameter int unsigned     DATABUS  = DATABUS_DEF,
  parameter int unsigned     COUNTLEN = COUNTLEN_DEF,
  parameter longint unsigned FAST_INC = FAST_INC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trig_i,
  input  logic               fast_i,
  input  logic               req_i,
  input  logic               atomic_i,
  output logic               ack_o,
  output logic [DATABUS-1:0] count_o
);

  logic [COUNTLEN-1:0] cnt_next;
  logic [DATABUS-1:0]  msb_q, msb_d, count_q, count_d;
  logic                ack_q, ack_d;
  rd_kind_e            kind;

  counter64 #(
    .COUNTLEN (COUNTLEN),
    .FAST_INC (FAST_INC)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .trig_i     (trig_i),
    .fast_i     (fast_i),
    .cnt_next_o (cnt_next)
  );

  always_comb begin
    kind    = rd_kind(req_i, atomic_i);
    msb_d   = msb_q;
    count_d = count_q;
    ack_d   = req_i;
    unique case (kind)
      RD_LSB: begin
        count_d = cnt_next[DATABUS-1:0];
        msb_d   = cnt_next[COUNTLEN-1 -: DATABUS];
      end
      RD_MSB:  count_d = msb_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msb_q   <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      msb_q   <= msb_d;
      count_q <= count_d;
      ack_q   <= ack_d;
    end
  end

  assign ack_o   = ack_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_atomic_counters.sv
// Self-checking bench: vector table, directed corner sequences, random run vs model.
module tb_atomic_counters;
  import atomic_counters_pkg::*;

  localparam longint unsigned WRAP_INC = 64'hFFFF_FFFF_FFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trig_i = 1'b0, fast_i = 1'b0, req_i = 1'b0, atomic_i = 1'b0;
  logic        ack_o, w_ack;
  logic [31:0] count_o, w_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  atomic_counters dut (
    .clk      (clk),
    .reset    (reset),
    .trig_i   (trig_i),
    .fast_i   (fast_i),
    .req_i    (req_i),
    .atomic_i (atomic_i),
    .ack_o    (ack_o),
    .count_o  (count_o)
  );

  // Second instance with a huge fast increment to reach the 64-bit wrap quickly
  atomic_counters #(.FAST_INC(WRAP_INC)) dut_w (
    .clk      (clk),
    .reset    (reset),
    .trig_i   (trig_i),
    .fast_i   (fast_i),
    .req_i    (req_i),
    .atomic_i (atomic_i),
    .ack_o    (w_ack),
    .count_o  (w_count)
  );

  typedef struct {
    longint unsigned cnt;
    logic [31:0]     msb;
    logic [31:0]     count;
    logic            ack;
  } mstate_t;

  mstate_t m, mw;

  function automatic mstate_t mclear();
    mstate_t s;
    s.cnt = 0; s.msb = '0; s.count = '0; s.ack = 1'b0;
    return s;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input longint unsigned finc,
                                    input logic t, input logic f, input logic r, input logic a);
    mstate_t n;
    longint unsigned nx;
    n  = s;
    nx = s.cnt + (t ? (f ? finc : 64'd1) : 64'd0);
    n.cnt = nx;
    n.ack = r;
    if (r && a) begin
      n.count = nx[31:0];
      n.msb   = nx[63:32];
    end else if (r) begin
      n.count = s.msb;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("ack", {63'd0, ack_o}, {63'd0, m.ack});
    chk("count", {32'd0, count_o}, {32'd0, m.count});
    chk("w_ack", {63'd0, w_ack}, {63'd0, mw.ack});
    chk("w_count", {32'd0, w_count}, {32'd0, mw.count});
  endtask

  task automatic step(input logic t, input logic f, input logic r, input logic a);
    @(negedge clk);
    trig_i = t; fast_i = f; req_i = r; atomic_i = a;
    @(posedge clk);
    if (reset) begin
      m  = mstep(m, FAST_INC_DEF, t, f, r, a);
      mw = mstep(mw, WRAP_INC, t, f, r, a);
    end
    #1;
    check_model();
  endtask

  // Asynchronous assert away from any edge; requests issued during reset must not ack
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_ack", {63'd0, ack_o}, 64'd0);
    chk("rst_async_cnt", {32'd0, count_o}, 64'd0);
    m  = mclear();
    mw = mclear();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_noack_a", {63'd0, ack_o}, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_noack_n", {63'd0, ack_o}, 64'd0);
    @(negedge clk);
    trig_i = 1'b0; fast_i = 1'b0; req_i = 1'b0; atomic_i = 1'b0;
    reset = 1'b1;
  endtask

  typedef struct {
    int unsigned n;
    logic        t, f, r, a;
    logic        eack;
    logic [31:0] ecnt;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            tbl[6];
    longint unsigned v, snap;
    logic [31:0]     lsb;
    logic            rolled;

    m  = mclear();
    mw = mclear();

    tbl[0] = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd11};
    tbl[2] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    tbl[3] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[4] = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0};
    tbl[5] = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1000012};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int unsigned k = 0; k < tbl[i].n; k++)
        step(tbl[i].t, tbl[i].f, tbl[i].r, tbl[i].a);
      chk($sformatf("tbl%0d_ack", i), {63'd0, ack_o}, {63'd0, tbl[i].eack});
      chk($sformatf("tbl%0d_cnt", i), {32'd0, count_o}, {32'd0, tbl[i].ecnt});
    end

    // Fast counting across the 32-bit boundary
    do_reset();
    repeat (5000) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("fast_lsb", {32'd0, count_o}, 64'h2A05_F201);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fast_msb", {32'd0, count_o}, 64'd1);

    // Held counter: repeated atomic reads agree, MSB read matches
    v = m.cnt;
    repeat (100) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("hold_lsb1", {32'd0, count_o}, {32'd0, v[31:0]});
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("hold_lsb2", {32'd0, count_o}, {32'd0, v[31:0]});
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hold_msb", {32'd0, count_o}, {32'd0, v[63:32]});
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hold_msb_again", {32'd0, count_o}, {32'd0, v[63:32]});

    // 64-bit wrap on the large-increment instance
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("wrap1_lsb", {32'd0, w_count}, 64'hFFFF_FFE0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap1_msb", {32'd0, w_count}, 64'hFFFF_FFFF);
    repeat (31) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("wrap2_lsb", {32'd0, w_count}, 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap2_msb", {32'd0, w_count}, 64'd0);

    // Running counter: pair stays coherent even after the live MSB moves on
    step(1'b1, 1'b1, 1'b1, 1'b1);
    snap   = m.cnt;
    lsb    = count_o;
    rolled = 1'b0;
    for (int i = 0; i < 10000 && !rolled; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      rolled = (m.cnt[63:32] != snap[63:32]);
    end
    chk("msb_rollover_seen", {63'd0, rolled}, 64'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("atomic_pair", {count_o, lsb}, snap);

    // Reset between atomic and MSB reads clears the snapshot
    step(1'b1, 1'b1, 1'b1, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_ack", {63'd0, ack_o}, 64'd1);
    chk("post_rst_msb", {32'd0, count_o}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) do_reset();
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
